reg_writeback_queue: RTL and testbench

- Initiator side of the register bank write port.
- Collects writeback results from the ALU and load/store paths through valid/ready handshakes and buffers them in a small in-order queue.
- Drains one entry per cycle onto the register bank write port.
- Reports pending writes, with forward data, for two read addresses so decode can detect RAW hazards.

---
 rtl/reg_writeback_queue.sv | 166 ++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// -----------------------------------------------------------------------------
// reg_writeback_queue
//   Initiator side of the register bank write port. ALU and load results are
//   accepted through valid/ready handshakes (load has fixed priority), held in
//   a small in-order circular queue and drained one entry per cycle onto the
//   register bank write port. Two combinational hazard queries report whether
//   a queued write targets a given register, with the youngest matching data.
//
//   Optional feature macro: WB_BYPASS_EN
//     When defined, a result offered while the queue is empty and the write
//     port is free is written in the same cycle without being enqueued.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   alu_valid/ready/addr/data     ALU writeback handshake
//   mem_valid/ready/addr/data     load writeback handshake (priority source)
//   wr_hold                       stall the drain; head entry held stable
//   regWriteEnable/Addr/Data      register bank write port
//   qry_addr_1/2                  hazard query addresses
//   qry_pend_1/2, qry_data_1/2    pending flag and youngest forward data
//   full, empty                   queue occupancy flags
// -----------------------------------------------------------------------------
module reg_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_addr,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   input  logic          wr_hold,
   output logic          regWriteEnable,
   output logic [AW-1:0] regWriteAddr,
   output logic [DW-1:0] regWriteData,
   input  logic [AW-1:0] qry_addr_1,
   input  logic [AW-1:0] qry_addr_2,
   output logic          qry_pend_1,
   output logic          qry_pend_2,
   output logic [DW-1:0] qry_data_1,
   output logic [DW-1:0] qry_data_2,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          accept;
   logic          push;
   logic          pop;
   logic          byp;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic [PW-1:0] idx;

   // Handshake and arbitration
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      empty     = (count_q == '0);
      mem_ready = !full;
      alu_ready = !full && !mem_valid;
      accept    = (mem_valid && mem_ready) || (alu_valid && alu_ready);
      // mem_valid alone decides the winner: alu can only be accepted when it is low
      in_addr   = mem_valid ? mem_addr : alu_addr;
      in_data   = mem_valid ? mem_data : alu_data;
`ifdef WB_BYPASS_EN
      byp       = empty && !wr_hold && accept;
`else
      byp       = 1'b0;
`endif
      push      = accept && !byp;
      pop       = !empty && !wr_hold;
   end

   // Write port: head entry when occupied, bypassed source when enabled, else 0
   always_comb begin
      regWriteEnable = pop || byp;
      regWriteAddr   = '0;
      regWriteData   = '0;
      if (!empty) begin
         regWriteAddr = addr_q[rd_ptr_q];
         regWriteData = data_q[rd_ptr_q];
      end else if (byp) begin
         regWriteAddr = in_addr;
         regWriteData = in_data;
      end
   end

   // Next-state
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         addr_d[wr_ptr_q] = in_addr;
         data_d[wr_ptr_q] = in_data;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   // Hazard query: scan oldest to youngest so the last match is the newest
   always_comb begin
      qry_pend_1 = 1'b0;
      qry_pend_2 = 1'b0;
      qry_data_1 = '0;
      qry_data_2 = '0;
      idx        = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (addr_q[idx] == qry_addr_1) begin
               qry_pend_1 = 1'b1;
               qry_data_1 = data_q[idx];
            end
            if (addr_q[idx] == qry_addr_2) begin
               qry_pend_2 = 1'b1;
               qry_data_2 = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid, wr_hold;
   logic          alu_ready, mem_ready;
   logic [AW-1:0] alu_addr, mem_addr, qry_addr_1, qry_addr_2;
   logic [DW-1:0] alu_data, mem_data;
   logic          regWriteEnable;
   logic [AW-1:0] regWriteAddr;
   logic [DW-1:0] regWriteData;
   logic          qry_pend_1, qry_pend_2;
   logic [DW-1:0] qry_data_1, qry_data_2;
   logic          full, empty;

   int n_cmp = 0;
   int n_err = 0;

   logic [AW+DW-1:0] sb [$];
   logic [AW+DW-1:0] exp_wr;

   reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .wr_hold(wr_hold),
      .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
      .qry_addr_1(qry_addr_1), .qry_addr_2(qry_addr_2),
      .qry_pend_1(qry_pend_1), .qry_pend_2(qry_pend_2),
      .qry_data_1(qry_data_1), .qry_data_2(qry_data_2),
      .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Scoreboard: record accepted results in handshake order, compare each write
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
      end else begin
         if (mem_valid && mem_ready)
            sb.push_back({mem_addr, mem_data});
         else if (alu_valid && alu_ready)
            sb.push_back({alu_addr, alu_data});
         if (regWriteEnable) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_write: got addr=%0d data=%h, expected no write", regWriteAddr, regWriteData);
            end else begin
               exp_wr = sb.pop_front();
               if ({regWriteAddr, regWriteData} !== exp_wr) begin
                  n_err++;
                  $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                           regWriteAddr, regWriteData, exp_wr[AW+DW-1:DW], exp_wr[DW-1:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty();
      int unsigned k;
      k = 0;
      while (!empty && k < 50) begin
         step();
         k++;
      end
      n_cmp++;
      if (empty !== 1'b1) begin
         n_err++;
         $display("FAIL wait_empty: empty=%b, expected 1 within 50 cycles", empty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) step();
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b exp 0", full); end
      n_cmp++; if (regWriteEnable !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b exp 0", regWriteEnable); end
      n_cmp++; if (regWriteData !== '0) begin n_err++; $display("FAIL rst_wdata: got %h exp 0", regWriteData); end
      rst = 1'b1;
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL rst_alu_ready: got %b exp 1", alu_ready); end
      n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_mem_ready: got %b exp 1", mem_ready); end
   endtask

   task automatic test_single_alu();
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
      #1;
      n_cmp++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 5'd5 || regWriteData !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_write: we=%b addr=%0d data=%h exp 1/5/deadbeef", regWriteEnable, regWriteAddr, regWriteData);
      end
      step();
      alu_valid = 1'b0;
`else
      step();
      alu_valid = 1'b0;
      #1;
      n_cmp++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 5'd5 || regWriteData !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_write: we=%b addr=%0d data=%h exp 1/5/deadbeef", regWriteEnable, regWriteAddr, regWriteData);
      end
      step();
`endif
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b exp 1", empty); end
   endtask

   task automatic test_priority();
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
      mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
      #1;
      n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL prio_alu_ready: got %b exp 0", alu_ready); end
      n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL prio_mem_ready: got %b exp 1", mem_ready); end
`ifndef WB_BYPASS_EN
      step();
      mem_valid = 1'b0;
      #1;
      n_cmp++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 5'd4) begin
         n_err++; $display("FAIL prio_first: we=%b addr=%0d exp 1/4", regWriteEnable, regWriteAddr);
      end
      step();
      alu_valid = 1'b0;
      #1;
      n_cmp++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 5'd3) begin
         n_err++; $display("FAIL prio_second: we=%b addr=%0d exp 1/3", regWriteEnable, regWriteAddr);
      end
`else
      step();
      mem_valid = 1'b0;
      step();
      alu_valid = 1'b0;
`endif
      wait_empty();
   endtask

   task automatic test_fill();
      wr_hold = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         alu_valid = 1'b1; alu_addr = AW'(10 + k); alu_data = 32'h100 + k;
         step();
      end
      alu_addr = 5'd14; alu_data = 32'h104;
      step();
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b exp 1", full); end
      n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL fill_alu_ready: got %b exp 0", alu_ready); end
      n_cmp++; if (regWriteEnable !== 1'b0) begin n_err++; $display("FAIL fill_held_we: got %b exp 0", regWriteEnable); end
      wr_hold = 1'b0;
      #1;
      for (int k = 0; k <= DEPTH; k++) begin
         n_cmp++; if (regWriteEnable !== 1'b1 || regWriteAddr !== AW'(10 + k)) begin
            n_err++; $display("FAIL fill_drain%0d: we=%b addr=%0d exp 1/%0d", k, regWriteEnable, regWriteAddr, 10 + k);
         end
         if (k == 0) begin
            n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL fill_pop_ready: got %b exp 0", alu_ready); end
         end
         @(posedge clk);
         #1;
         if (k == 1) alu_valid = 1'b0;
         #1;
      end
      wait_empty();
   endtask

   task automatic test_forwarding();
      wr_hold = 1'b1;
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h1;
      step();
      alu_data = 32'h2;
      step();
      alu_addr = 5'd0; alu_data = 32'h33;
      step();
      alu_valid = 1'b0;
      qry_addr_1 = 5'd7; qry_addr_2 = 5'd8;
      #1;
      n_cmp++; if (qry_pend_1 !== 1'b1) begin n_err++; $display("FAIL fwd_pend1: got %b exp 1", qry_pend_1); end
      n_cmp++; if (qry_data_1 !== 32'h2) begin n_err++; $display("FAIL fwd_data1: got %h exp 2", qry_data_1); end
      n_cmp++; if (qry_pend_2 !== 1'b0) begin n_err++; $display("FAIL fwd_pend2: got %b exp 0", qry_pend_2); end
      n_cmp++; if (qry_data_2 !== 32'h0) begin n_err++; $display("FAIL fwd_data2: got %h exp 0", qry_data_2); end
      qry_addr_2 = 5'd0;
      #1;
      n_cmp++; if (qry_pend_2 !== 1'b1 || qry_data_2 !== 32'h33) begin
         n_err++; $display("FAIL fwd_addr0: pend=%b data=%h exp 1/33", qry_pend_2, qry_data_2);
      end
      wr_hold = 1'b0;
      wait_empty();
      n_cmp++; if (qry_pend_1 !== 1'b0) begin n_err++; $display("FAIL fwd_drained: got %b exp 0", qry_pend_1); end
   endtask

   task automatic test_reset_mid_drain();
      wr_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_addr = AW'(20 + k); alu_data = 32'h200 + k;
         step();
      end
      alu_valid = 1'b0;
      wr_hold = 1'b0;
      step();
      qry_addr_1 = 5'd21;
      #1;
      n_cmp++; if (qry_pend_1 !== 1'b1) begin n_err++; $display("FAIL mid_pend: got %b exp 1", qry_pend_1); end
      rst = 1'b0;
      #1;
      n_cmp++; if (regWriteEnable !== 1'b0) begin n_err++; $display("FAIL mid_rst_we: got %b exp 0", regWriteEnable); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty: got %b exp 1", empty); end
      n_cmp++; if (regWriteAddr !== '0) begin n_err++; $display("FAIL mid_rst_addr: got %0d exp 0", regWriteAddr); end
      n_cmp++; if (qry_pend_1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_pend: got %b exp 0", qry_pend_1); end
      repeat (2) step();
      rst = 1'b1;
      #1;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %b exp 1", alu_ready); end
      step();
      n_cmp++; if (regWriteEnable !== 1'b0) begin n_err++; $display("FAIL mid_rel_we: got %b exp 0", regWriteEnable); end
   endtask

`ifdef WB_BYPASS_EN
   task automatic test_bypass();
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'hA5;
      #1;
      n_cmp++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 5'd9 || regWriteData !== 32'hA5) begin
         n_err++; $display("FAIL bypass_write: we=%b addr=%0d data=%h exp 1/9/a5", regWriteEnable, regWriteAddr, regWriteData);
      end
      step();
      alu_valid = 1'b0;
      #1;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL bypass_count: empty=%b exp 1", empty); end
   endtask
`endif

   initial begin
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
      wr_hold = 1'b0; qry_addr_1 = '0; qry_addr_2 = '0;
      test_reset();
      test_single_alu();
      test_priority();
      test_fill();
      test_forwarding();
      test_reset_mid_drain();
`ifdef WB_BYPASS_EN
      test_bypass();
`endif
      repeat (3) step();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: %0d writes outstanding, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
